approx_mult_controller: RTL

- FSM controller for the approximate-multiplier datapath.
- Sequences operand load, leading-one normalisation of both 16-bit operands, 8x8 multiply, result de-normalisation and result write-back, over a block of operand pairs.
- Consumes the datapath status flags and drives every load, count, shift and write-enable the datapath needs.
- Sits directly above the datapath; talks to top level through start/busy/done/err.

---
 rtl/approx_mult_controller.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/approx_mult_controller.sv
// approx_mult_controller
//   FSM sequencer for the approximate-multiplier datapath. For each operand
//   pair in a block it loads both operands and normalises them by their
//   leading one. It then multiplies, de-normalises the product and writes
//   it back. The block ends when the datapath reports the last pair.
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   start                 begin a block (accepted in IDLE only)
//   countdone1/2          operand A/B normalised
//   carry2                reserved, ignored
//   carry3                result shift counter terminal
//   carry4                pair counter at last pair
//   ld1..ld5              datapath load strobes
//   Inc1..Inc4            counter increments
//   Countrst1..Countrst4  synchronous counter clears
//   Shle1, Shle2, Shre    operand / result shift enables
//   We                    output memory write enable
//   busy, done, err       status: active, completion pulse, sticky watchdog abort
module approx_mult_controller #(
  parameter int unsigned WATCHDOG = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic countdone1,
  input  logic countdone2,
  input  logic carry2,
  input  logic carry3,
  input  logic carry4,
  output logic ld1,
  output logic ld2,
  output logic ld3,
  output logic ld4,
  output logic ld5,
  output logic Inc1,
  output logic Inc2,
  output logic Inc3,
  output logic Inc4,
  output logic Countrst1,
  output logic Countrst2,
  output logic Countrst3,
  output logic Countrst4,
  output logic Shle1,
  output logic Shle2,
  output logic Shre,
  output logic We,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int unsigned WD_W = $clog2(WATCHDOG + 1);
  // Abort on the WATCHDOG-th cycle spent waiting, counting from zero.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_LOAD,
    S_NORM,
    S_MULT,
    S_DENORM,
    S_WRITE,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  logic unused_carry2;
  assign unused_carry2 = carry2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    err_d     = err_q;
    ld1       = 1'b0;
    ld2       = 1'b0;
    ld3       = 1'b0;
    ld4       = 1'b0;
    ld5       = 1'b0;
    Inc1      = 1'b0;
    Inc2      = 1'b0;
    Inc3      = 1'b0;
    Inc4      = 1'b0;
    Countrst1 = 1'b0;
    Countrst2 = 1'b0;
    Countrst3 = 1'b0;
    Countrst4 = 1'b0;
    Shle1     = 1'b0;
    Shle2     = 1'b0;
    Shre      = 1'b0;
    We        = 1'b0;
    done      = 1'b0;
    busy      = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT;
          err_d   = 1'b0;
        end
      end
      S_INIT: begin
        Countrst4 = 1'b1;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        ld1       = 1'b1;
        ld2       = 1'b1;
        Countrst1 = 1'b1;
        Countrst2 = 1'b1;
        Countrst3 = 1'b1;
        wd_d      = '0;
        state_d   = S_NORM;
      end
      S_NORM: begin
        Shle1 = !countdone1;
        Inc1  = !countdone1;
        Shle2 = !countdone2;
        Inc2  = !countdone2;
        if (countdone1 && countdone2) begin
          state_d = S_MULT;
        end else if (wd_q == WD_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_MULT: begin
        ld3     = 1'b1;
        ld4     = 1'b1;
        wd_d    = '0;
        state_d = S_DENORM;
      end
      S_DENORM: begin
        Shre = !carry3;
        Inc3 = !carry3;
        if (carry3) begin
          state_d = S_WRITE;
        end else if (wd_q == WD_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_WRITE: begin
        ld5     = 1'b1;
        We      = 1'b1;
        Inc4    = 1'b1;
        state_d = carry4 ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign err = err_q;

endmodule
